// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with valid/ready handshake and a 2-entry skid buffer.
// Extracts the I/S/B/U/J/shamt immediate, optionally decoding the format from the opcode.
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter bit          AUTO_DECODE = 1'b0,
  parameter int unsigned TAG_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immediate,
  output logic             imm_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [2:0] FMT_I   = 3'b000;
  localparam logic [2:0] FMT_S   = 3'b001;
  localparam logic [2:0] FMT_B   = 3'b010;
  localparam logic [2:0] FMT_U   = 3'b011;
  localparam logic [2:0] FMT_J   = 3'b100;
  localparam logic [2:0] FMT_SH  = 3'b101;
  localparam logic [2:0] FMT_BAD = 3'b110;

  logic [1:0]      state, state_nxt;
  logic [2:0]      auto_fmt_c, fmt_c;
  logic [31:0]     imm32_c;
  logic            is_shamt_c, err_c;
  logic [XLEN-1:0] imm_c;
  logic            accept_c, drain_c;
  logic            load_out_in_c, load_out_skid_c, load_skid_c;

  logic [XLEN-1:0]  skid_imm;
  logic             skid_err;
  logic [TAG_W-1:0] skid_tag;

  // Format derived from opcode/funct3
  always_comb begin
    auto_fmt_c = FMT_BAD;
    case (instruction[6:0])
      7'b0010011: auto_fmt_c = (instruction[13:12] == 2'b01) ? FMT_SH : FMT_I;
      7'b0000011,
      7'b1100111: auto_fmt_c = FMT_I;
      7'b0100011: auto_fmt_c = FMT_S;
      7'b1100011: auto_fmt_c = FMT_B;
      7'b0110111,
      7'b0010111: auto_fmt_c = FMT_U;
      7'b1101111: auto_fmt_c = FMT_J;
      default:    auto_fmt_c = FMT_BAD;
    endcase
  end

  assign fmt_c = AUTO_DECODE ? auto_fmt_c : imm_src;

  // Immediate sign-extended to 32 bits; shamt handled separately as it zero-extends
  always_comb begin
    imm32_c    = '0;
    is_shamt_c = 1'b0;
    err_c      = 1'b0;
    case (fmt_c)
      FMT_I:  imm32_c = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S:  imm32_c = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B:  imm32_c = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                         instruction[11:8], 1'b0};
      FMT_U:  imm32_c = {instruction[31:12], 12'b0};
      FMT_J:  imm32_c = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                         instruction[30:21], 1'b0};
      FMT_SH: is_shamt_c = 1'b1;
      default: err_c = 1'b1;
    endcase
  end

  if (XLEN == 64) begin : g_x64
    assign imm_c = is_shamt_c ? XLEN'({58'd0, instruction[25:20]})
                              : XLEN'({{32{imm32_c[31]}}, imm32_c});
  end else begin : g_x32
    assign imm_c = is_shamt_c ? XLEN'({27'd0, instruction[24:20]}) : XLEN'(imm32_c);
  end

  assign accept_c = in_valid && in_ready;
  assign drain_c  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Occupancy transitions and register load selects
  always_comb begin
    state_nxt       = state;
    load_out_in_c   = 1'b0;
    load_out_skid_c = 1'b0;
    load_skid_c     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept_c) begin
          state_nxt     = ST_ONE;
          load_out_in_c = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept_c && drain_c) begin
          load_out_in_c = 1'b1;
        end else if (accept_c) begin
          state_nxt   = ST_TWO;
          load_skid_c = 1'b1;
        end else if (drain_c) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain_c) begin
          state_nxt       = ST_ONE;
          load_out_skid_c = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      immediate <= '0;
      imm_err   <= 1'b0;
      out_tag   <= '0;
      skid_imm  <= '0;
      skid_err  <= 1'b0;
      skid_tag  <= '0;
    end else begin
      out_valid <= (state_nxt != ST_EMPTY);
      in_ready  <= (state_nxt != ST_TWO);
      if (load_out_in_c) begin
        immediate <= imm_c;
        imm_err   <= err_c;
        out_tag   <= in_tag;
      end else if (load_out_skid_c) begin
        immediate <= skid_imm;
        imm_err   <= skid_err;
        out_tag   <= skid_tag;
      end
      if (load_skid_c) begin
        skid_imm <= imm_c;
        skid_err <= err_c;
        skid_tag <= in_tag;
      end
    end
  end

endmodule
